// File: rtl/mux_arb_n.sv
`default_nettype none
// ============================================================================
//  Module   : mux_arb_n
//  Purpose  : N-channel, W-bit registered multiplexer with valid/ready
//             handshakes. Selects a channel either from an external index
//             (fixed mode) or in round-robin order (arbitrated mode) and
//             registers the winning beat into a one-entry output stage.
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             mode, sel       - 0: fixed select via sel, 1: round-robin
//             in_valid/in_ready/in_data - per-channel input handshakes,
//                               channel i data at [i*WIDTH +: WIDTH]
//             in_last         - per-channel end-of-burst (MUX_ARB_LAST_EN)
//             out_valid/out_ready/out_data/out_ch - registered output stage
//  Options  : define MUX_ARB_LAST_EN to add in_last and burst locking
//  Revision : 1.0 - initial release
// ============================================================================
module mux_arb_n #(
    parameter int WIDTH = 32,
    parameter int CH    = 8,
    parameter int SELW  = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    input  logic [CH-1:0]         in_valid,
    output logic [CH-1:0]         in_ready,
    input  logic [CH*WIDTH-1:0]   in_data,
`ifdef MUX_ARB_LAST_EN
    input  logic [CH-1:0]         in_last,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_ch
);

    // Channel count at index width plus one, so CH=16 is representable.
    localparam logic [SELW:0] c_CH = (SELW+1)'(CH);

    logic [WIDTH-1:0] w_dat [CH];
    logic [SELW-1:0]  r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_ch;

    logic             w_rr_vld;
    logic [SELW-1:0]  w_rr_gnt;
    logic [SELW:0]    w_idx;
    logic             w_fix_vld;
    logic             w_gnt_vld;
    logic [SELW-1:0]  w_gnt;
    logic             w_load;
    logic             w_xfer;
    logic             w_last;
    logic [SELW-1:0]  w_ptr_nxt;

    for (genvar i = 0; i < CH; i++) begin : g_slice
        assign w_dat[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Round-robin scan ptr, ptr+1, ... wrapping at CH. The loop runs from the
    // far end toward ptr so the nearest requesting channel is written last.
    always_comb begin
        w_rr_vld = 1'b0;
        w_rr_gnt = '0;
        w_idx    = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + (SELW+1)'(k);
            if (w_idx >= c_CH) begin
                w_idx = w_idx - c_CH;
            end
            if (in_valid[w_idx[SELW-1:0]]) begin
                w_rr_vld = 1'b1;
                w_rr_gnt = w_idx[SELW-1:0];
            end
        end
    end

    // Out-of-range select never grants, so the bit read is masked off.
    assign w_fix_vld = ({1'b0, sel} < c_CH) && in_valid[sel];

`ifdef MUX_ARB_LAST_EN
    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } lock_state_t;

    lock_state_t     r_state;
    logic [SELW-1:0] r_lock_ch;

    // While locked only the burst owner may be granted, regardless of mode.
    always_comb begin
        if (r_state == ST_LOCK) begin
            w_gnt_vld = in_valid[r_lock_ch];
            w_gnt     = r_lock_ch;
        end else if (mode) begin
            w_gnt_vld = w_rr_vld;
            w_gnt     = w_rr_gnt;
        end else begin
            w_gnt_vld = w_fix_vld;
            w_gnt     = sel;
        end
    end

    assign w_last = in_last[w_gnt];
`else
    assign w_gnt_vld = mode ? w_rr_vld : w_fix_vld;
    assign w_gnt     = mode ? w_rr_gnt : sel;
    assign w_last    = 1'b1;
`endif

    assign w_load    = ~r_out_valid | out_ready;
    // rst gating keeps in_ready low while reset is held (state is already idle).
    assign w_xfer    = w_load & w_gnt_vld & ~rst;
    assign in_ready  = w_xfer ? (CH'(1) << w_gnt) : '0;
    assign w_ptr_nxt = ({1'b0, w_gnt} == c_CH - 1'b1) ? '0 : w_gnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_dat[w_gnt];
                r_out_ch    <= w_gnt;
                // Mid-burst beats leave the fairness pointer alone.
                if (w_last) begin
                    r_ptr <= w_ptr_nxt;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef MUX_ARB_LAST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_ARB;
            r_lock_ch <= '0;
        end else if (w_xfer) begin
            case (r_state)
                ST_ARB: begin
                    if (!w_last) begin
                        r_state   <= ST_LOCK;
                        r_lock_ch <= w_gnt;
                    end
                end
                ST_LOCK: begin
                    if (w_last) begin
                        r_state <= ST_ARB;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_arb_n
//  Purpose  : Directed self-checking bench for mux_arb_n (CH=8, WIDTH=32)
//             plus a CH=5 instance for out-of-range select.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_arb_n;

    localparam int W = 32;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           mode = 1'b0;
    logic [2:0]     sel = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic [2:0]     out_ch;

    // Five-channel instance: 3-bit select can address channels 5..7.
    logic [2:0]     sel5 = '0;
    logic [4:0]     v5 = '0;
    logic [4:0]     r5;
    logic [39:0]    d5 = '0;
    logic           ov5;
    logic [7:0]     od5;
    logic [2:0]     oc5;

`ifdef MUX_ARB_LAST_EN
    logic [N-1:0]   in_last = '0;
    logic [4:0]     l5 = '1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_arb_n #(.WIDTH(W), .CH(N)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef MUX_ARB_LAST_EN
        .in_last   (in_last),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    mux_arb_n #(.WIDTH(8), .CH(5)) u_dut5 (
        .clk       (clk),
        .rst       (rst),
        .mode      (1'b0),
        .sel       (sel5),
        .in_valid  (v5),
        .in_ready  (r5),
        .in_data   (d5),
`ifdef MUX_ARB_LAST_EN
        .in_last   (l5),
`endif
        .out_valid (ov5),
        .out_ready (1'b1),
        .out_data  (od5),
        .out_ch    (oc5)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] fair_seq [4];

    initial begin
        fair_seq = '{3'd2, 3'd6, 3'd2, 3'd6};
        for (int i = 0; i < N; i++) begin
            in_data[i*W +: W] = 32'hA0 + i;
        end

        // Reset held: outputs idle, in_ready gated even with requests pending.
        in_valid = 8'hFF;
        v5       = 5'h1F;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data, 0);
        chk("rst_out_ch",    out_ch, 0);
        chk("rst_in_ready",  in_ready, 0);
        tick;
        tick;
        rst = 1'b0;

        // Fixed select of channel 5.
        mode = 1'b0; sel = 3'd5; out_ready = 1'b1;
        #1;
        chk("fix_in_ready", in_ready, 8'h20);
        tick;
        chk("fix_out_valid", out_valid, 1);
        chk("fix_out_data",  out_data, 32'hA5);
        chk("fix_out_ch",    out_ch, 5);
        chk("fix_in_ready2", in_ready, 8'h20);
        tick;
        chk("fix_beat2_valid", out_valid, 1);

        // Out-of-range select on the five-channel instance.
        sel5 = 3'd6; #1;
        chk("sel_oor6", r5, 0);
        sel5 = 3'd7; #1;
        chk("sel_oor7", r5, 0);
        sel5 = 3'd4; #1;
        chk("sel_in4", r5, 5'h10);

        // No request while output drains: valid drops, payload holds.
        in_valid = '0;
        tick;
        chk("drain_valid", out_valid, 0);
        chk("drain_ch",    out_ch, 5);
        chk("drain_data",  out_data, 32'hA5);

        // Asynchronous reset mid-transfer.
        in_valid = 8'hFF;
        tick;
        chk("pre_rst_valid", out_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid",    out_valid, 0);
        chk("arst_data",     out_data, 0);
        chk("arst_ch",       out_ch, 0);
        chk("arst_in_ready", in_ready, 0);
        rst  = 1'b0;
        mode = 1'b1;
        in_valid = 8'h64;
        #1;
        chk("rr_first_low", in_ready, 8'h04);
        in_valid = 8'hFF;
        #1;
        chk("rr_first_all", in_ready, 8'h01);

        // Round-robin over all channels with wrap, one beat per cycle.
        for (int k = 0; k < 9; k++) begin
            tick;
            chk("rr_valid", out_valid, 1);
            chk("rr_ch",    out_ch, k % 8);
            chk("rr_data",  out_data, 32'hA0 + (k % 8));
        end

        // Fairness between channels 2 and 6 (pointer now at 1).
        in_valid = 8'h44;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("fair_ch", out_ch, fair_seq[k]);
        end

        // Back-pressure: beat from channel 6 must hold.
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready", in_ready, 0);
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("bp_valid", out_valid, 1);
            chk("bp_data",  out_data, 32'hA6);
        end
        in_valid  = 8'h08;
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 8'h08);
        tick;
        chk("replace_valid", out_valid, 1);
        chk("replace_ch",    out_ch, 3);
        chk("replace_data",  out_data, 32'hA3);

        // Fixed-mode transfers also advance the round-robin pointer.
        mode = 1'b0; sel = 3'd5; in_valid = 8'hFF;
        tick;
        mode = 1'b1;
        #1;
        chk("fix_ptr_adv", in_ready, 8'h40);

`ifdef MUX_ARB_LAST_EN
        // Burst lock: channel 1 sends three beats while channel 4 waits.
        rst = 1'b1; #1; rst = 1'b0;
        in_last  = '0;
        in_valid = 8'h12;
        #1;
        chk("lk_first", in_ready, 8'h02);
        tick;
        chk("lk_b1", out_ch, 1);
        mode = 1'b0; sel = 3'd4;
        #1;
        chk("lk_hold", in_ready, 8'h02);
        tick;
        chk("lk_b2", out_ch, 1);
        in_last = 8'h02;
        tick;
        chk("lk_b3", out_ch, 1);
        mode = 1'b1; in_last = '0;
        #1;
        chk("lk_next", in_ready, 8'h10);
        tick;
        chk("lk_ch4", out_ch, 4);
        // Now locked on channel 4; reset must return to arbitration.
        #2; rst = 1'b1; #1; rst = 1'b0;
        in_valid = 8'h02;
        #1;
        chk("lk_rst_arb", in_ready, 8'h02);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
